// File: rtl/dnn_ctrl_pkg.sv
// Shared constants for the detection/alert controller: FSM encoding,
// default parameter values and small helpers.
package dnn_ctrl_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_ALERT = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam int DEF_HITS           = 2;
  localparam int DEF_GAP_CYCLES     = 2000000;
  localparam int DEF_BEEP_CYCLES    = 50000000;
  localparam int DEF_TONE_HALF      = 6250;
  localparam int DEF_HOLDOFF_CYCLES = 25000000;
  localparam int DEF_THR_PRV        = 8000;
  localparam int DEF_THR_PUB        = 7500;

  // Counter width for a timer of p clocks: ceil(log2(p)), never below 1 bit.
  function automatic int tw(input int p);
    return (p <= 1) ? 1 : $clog2(p);
  endfunction

  // 8-bit increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/detect_alert_ctrl_if.sv
// Matcher <-> controller link: result strobe, hit flag, VAD flag and
// the threshold fed back to the matcher.
interface detect_alert_ctrl_if;
  logic        result_dv;
  logic        result;
  logic        vad_in;
  logic [15:0] thr_o;

  modport master (output result_dv, output result, output vad_in, input thr_o);
  modport slave  (input result_dv, input result, input vad_in, output thr_o);
endinterface

// File: rtl/alert_timer.sv
// Loadable down-counter. A load starts it at val_i; it counts to zero and
// raises done_o for the single clock it sits at zero, then idles.
module alert_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic         run_q;

  // Load has priority; otherwise count down while running, stop after zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load_i) begin
      cnt_q <= val_i;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/detect_alert_ctrl.sv
// Alert controller: counts consecutive matcher hits, sounds a tone and
// lights the LED for a fixed time, then enforces a refractory holdoff.
module detect_alert_ctrl
  import dnn_ctrl_pkg::*;
#(
  parameter int HITS           = DEF_HITS,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int BEEP_CYCLES    = DEF_BEEP_CYCLES,
  parameter int TONE_HALF      = DEF_TONE_HALF,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int THR_PRV        = DEF_THR_PRV,
  parameter int THR_PUB        = DEF_THR_PUB
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      switch,
  detect_alert_ctrl_if.slave        m,
  output logic                      beep,
  output logic                      led_det,
  output logic                      led_vad,
  output logic [7:0]                det_cnt
);

  localparam int GW  = tw(GAP_CYCLES);
  localparam int BW  = tw(BEEP_CYCLES);
  localparam int HW  = tw(HOLDOFF_CYCLES);
  localparam int TNW = tw(TONE_HALF);

  // Timers run from P-1 down to 0, i.e. exactly P clocks.
  localparam logic [GW-1:0]  GAP_LD    = GW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0]  BEEP_LD   = BW'(BEEP_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_LD   = (HOLDOFF_CYCLES == 0) ? '0 : HW'(HOLDOFF_CYCLES - 1);
  localparam logic [TNW-1:0] TONE_LAST = TNW'(TONE_HALF - 1);

  logic [1:0]     state_q, state_d;
  logic [3:0]     hit_q, hit_d, hit_inc;
  logic [TNW-1:0] tone_q;
  logic           beep_q, led_det_q, led_vad_q;
  logic [7:0]     det_q;
  logic [15:0]    thr_q;
  logic           hit_pos, hit_neg;
  logic           gap_ld, beep_ld, hold_ld;
  logic           gap_done, beep_done, hold_done;

  assign hit_pos = m.result_dv &  m.result;
  assign hit_neg = m.result_dv & ~m.result;
  assign hit_inc = hit_q + 4'd1;

  // Next-state and hit-count logic; strobes only matter in IDLE/ARMED.
  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    gap_ld  = 1'b0;
    case (state_q)
      S_IDLE: if (hit_pos) begin
        if (HITS == 1) begin
          state_d = S_ALERT;
          hit_d   = '0;
        end else begin
          state_d = S_ARMED;
          hit_d   = 4'd1;
          gap_ld  = 1'b1;
        end
      end
      S_ARMED: begin
        if (hit_pos) begin
          if (hit_inc == 4'(HITS)) begin
            state_d = S_ALERT;
            hit_d   = '0;
          end else begin
            hit_d  = hit_inc;
            gap_ld = 1'b1;
          end
        end else if (hit_neg || gap_done) begin
          state_d = S_IDLE;
          hit_d   = '0;
        end
      end
      S_ALERT: if (beep_done) state_d = (HOLDOFF_CYCLES == 0) ? S_IDLE : S_HOLD;
      S_HOLD:  if (hold_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign beep_ld = (state_d == S_ALERT) && (state_q != S_ALERT);
  assign hold_ld = (state_q == S_ALERT) && (state_d == S_HOLD);

  alert_timer #(.W(GW)) u_gap  (.clk(clk), .reset(reset), .load_i(gap_ld),  .val_i(GAP_LD),  .done_o(gap_done));
  alert_timer #(.W(BW)) u_beep (.clk(clk), .reset(reset), .load_i(beep_ld), .val_i(BEEP_LD), .done_o(beep_done));
  alert_timer #(.W(HW)) u_hold (.clk(clk), .reset(reset), .load_i(hold_ld), .val_i(HOLD_LD), .done_o(hold_done));

  // FSM state, hit count and the simple registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      hit_q     <= '0;
      led_det_q <= 1'b0;
      led_vad_q <= 1'b0;
      thr_q     <= 16'(THR_PRV);
    end else begin
      state_q   <= state_d;
      hit_q     <= hit_d;
      led_det_q <= (state_d == S_ALERT);
      led_vad_q <= m.vad_in;
      thr_q     <= switch ? 16'(THR_PRV) : 16'(THR_PUB);
    end
  end

  // Tone generator and alert counter: start high on ALERT entry, toggle
  // every TONE_HALF clocks, forced low as soon as ALERT is left.
  always_ff @(posedge clk) begin
    if (!reset) begin
      beep_q <= 1'b0;
      tone_q <= '0;
      det_q  <= '0;
    end else if (beep_ld) begin
      beep_q <= 1'b1;
      tone_q <= '0;
      det_q  <= sat_inc8(det_q);
    end else if (state_d == S_ALERT) begin
      if (tone_q == TONE_LAST) begin
        beep_q <= ~beep_q;
        tone_q <= '0;
      end else begin
        tone_q <= tone_q + 1'b1;
      end
    end else begin
      beep_q <= 1'b0;
      tone_q <= '0;
    end
  end

  assign m.thr_o   = thr_q;
  assign beep      = beep_q;
  assign led_det   = led_det_q;
  assign led_vad   = led_vad_q;
  assign det_cnt   = det_q;

endmodule

// File: tb/tb_detect_alert_ctrl.sv
// Directed bench for detect_alert_ctrl with short timers.
module tb_detect_alert_ctrl;
  import dnn_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       switch = 1'b1;
  logic       beep, led_det, led_vad;
  logic [7:0] det_cnt;
  int         total = 0;
  int         bad = 0;
  int         exp_det;

  detect_alert_ctrl_if mif();

  detect_alert_ctrl #(
    .HITS(2), .GAP_CYCLES(100), .BEEP_CYCLES(40), .TONE_HALF(5), .HOLDOFF_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .switch(switch), .m(mif),
    .beep(beep), .led_det(led_det), .led_vad(led_vad), .det_cnt(det_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse(input logic r);
    mif.result_dv = 1'b1;
    mif.result    = r;
    tick();
    mif.result_dv = 1'b0;
    mif.result    = 1'b0;
  endtask

  initial begin
    mif.result_dv = 1'b0;
    mif.result    = 1'b0;
    mif.vad_in    = 1'b0;
    wait_n(2);

    // reset state
    chk("rst_state", dut.state_q, S_IDLE);
    chk("rst_beep", beep, 0);
    chk("rst_led_det", led_det, 0);
    chk("rst_led_vad", led_vad, 0);
    chk("rst_det_cnt", det_cnt, 0);
    chk("rst_thr", mif.thr_o, 8000);
    reset = 1'b1;

    // VAD follows with one clock of latency
    mif.vad_in = 1'b1;
    chk("vad_pre", led_vad, 0);
    tick();
    chk("vad_on", led_vad, 1);
    mif.vad_in = 1'b0;
    tick();
    chk("vad_off", led_vad, 0);

    // two hits 10 clocks apart, hits during ALERT/HOLDOFF ignored
    pulse(1'b1);
    chk("armed", dut.state_q, S_ARMED);
    wait_n(9);
    pulse(1'b1);
    chk("alert_state", dut.state_q, S_ALERT);
    chk("alert_det1", det_cnt, 1);
    chk("alert_led", led_det, 1);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("beep_%0d", i), beep, ((i / 5) % 2 == 0) ? 1 : 0);
      mif.result_dv = (i == 7 || i == 20 || i == 21);
      mif.result    = 1'b1;
      tick();
    end
    mif.result_dv = 1'b0;
    chk("hold_state", dut.state_q, S_HOLD);
    chk("hold_beep", beep, 0);
    chk("hold_led", led_det, 0);
    for (int i = 0; i < 20; i++) begin
      mif.result_dv = (i % 6 == 1);
      mif.result    = 1'b1;
      tick();
    end
    mif.result_dv = 1'b0;
    chk("hold_end_idle", dut.state_q, S_IDLE);
    chk("hold_det1", det_cnt, 1);
    pulse(1'b1);
    wait_n(2);
    pulse(1'b1);
    chk("alert2_state", dut.state_q, S_ALERT);
    chk("alert2_det2", det_cnt, 2);
    wait_n(60);
    chk("alert2_idle", dut.state_q, S_IDLE);

    // gap timeout
    pulse(1'b1);
    wait_n(99);
    chk("gap_last_armed", dut.state_q, S_ARMED);
    tick();
    chk("gap_idle", dut.state_q, S_IDLE);
    pulse(1'b1);
    chk("gap_single_armed", dut.state_q, S_ARMED);
    wait_n(100);
    chk("gap_single_idle", dut.state_q, S_IDLE);
    chk("gap_det", det_cnt, 2);

    // negative break
    pulse(1'b1);
    pulse(1'b0);
    chk("neg_idle", dut.state_q, S_IDLE);
    pulse(1'b1);
    chk("neg_rearm", dut.state_q, S_ARMED);
    chk("neg_det", det_cnt, 2);
    pulse(1'b0);
    chk("neg_idle2", dut.state_q, S_IDLE);

    // threshold select
    switch = 1'b0;
    chk("thr_pre", mif.thr_o, 8000);
    tick();
    chk("thr_pub", mif.thr_o, 7500);
    reset = 1'b0;
    tick();
    chk("thr_rst", mif.thr_o, 8000);
    chk("thr_rst_det", det_cnt, 0);
    reset = 1'b1;
    tick();
    chk("thr_pub2", mif.thr_o, 7500);
    switch = 1'b1;
    tick();
    chk("thr_prv", mif.thr_o, 8000);

    // reset mid-beep at ALERT clock 15
    pulse(1'b1);
    pulse(1'b1);
    chk("mid_alert", dut.state_q, S_ALERT);
    chk("mid_det", det_cnt, 1);
    wait_n(14);
    chk("mid_beep15", beep, 1);
    reset = 1'b0;
    tick();
    chk("mid_beep_off", beep, 0);
    chk("mid_idle", dut.state_q, S_IDLE);
    chk("mid_led", led_det, 0);
    chk("mid_det0", det_cnt, 0);
    reset = 1'b1;
    tick();

    // det_cnt saturation
    exp_det = 0;
    for (int n = 0; n < 256; n++) begin
      pulse(1'b1);
      pulse(1'b1);
      exp_det = (exp_det == 255) ? 255 : exp_det + 1;
      chk($sformatf("sat_%0d", n), det_cnt, exp_det);
      wait_n(60);
    end
    chk("sat_idle", dut.state_q, S_IDLE);
    chk("sat_final", det_cnt, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
